fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch and PC-sequencing front end that feeds the control unit.
- Holds the PC and reads the synchronous instruction memory.
- Latches the instruction word and presents opcode/register/immediate fields to the control unit.
- Consumes the control unit's registered PC-select code and updates the PC.
- This is the producer end of the opcode → pc_sel loop; each instruction runs through a fixed 4-state sequence.

Parameters:
PC_WIDTH, 16, PC/instruction-address width; legal range 8..16.
INSTR_WIDTH, 32, instruction word width; fixed at 32.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
im_addr  output  PC_WIDTH  instruction memory address; always equals current pc
im_rdata  input  32  instruction memory read data, valid 1 cycle after im_addr
opcode  output  6  IR[31:26] to control unit
rs1  output  5  IR[25:21]
rs2  output  5  IR[20:16]
imm  output  16  IR[15:0]
instr_valid  output  1  high while IR fields are valid for decode/execute
pc_sel  input  3  PC-select code from control unit
jr_target  input  PC_WIDTH  register-sourced jump target, used when pc_sel=2
stall  input  1  holds the EXEC state; the PC does not advance
pc  output  PC_WIDTH  current PC
halted  output  1  high in HALT state
illegal_sel  output  1  sticky flag, set when pc_sel is 5..7 at PC update

Behaviour:
- Reset (synchronous, any state): pc=RESET_PC, IR=0 (opcode=0, rs1=0, rs2=0, imm=0), instr_valid=0, halted=0, illegal_sel=0, state=FETCH. Any in-flight instruction is discarded.
- States: FETCH → LATCH → DECODE → EXEC → (FETCH | HALT).
- FETCH: im_addr=pc; the memory performs its read; next state is LATCH.
- LATCH: im_rdata is valid; IR<=im_rdata at the end of the cycle; next state is DECODE; instr_valid=0.
- DECODE: instr_valid=1 and the fields come from IR. The control unit registers its outputs at the end of this cycle. Next state is EXEC.
- EXEC: instr_valid=1 and IR is unchanged. pc_sel is sampled at the end of the cycle:
  - If stall=1: remain in EXEC; pc and IR are unchanged.
  - 0: pc<=imm[PC_WIDTH-1:0] (absolute jump).
  - 1: pc<=pc+1+sign_extend(imm), truncated mod 2^PC_WIDTH (taken branch).
  - 2: pc<=jr_target.
  - 3: pc<=pc+1 mod 2^PC_WIDTH (sequential).
  - 4: pc is unchanged; next state is HALT.
  - 5..7: treated as 3 and set illegal_sel.
  - For codes 0..3 and 5..7, next state is FETCH.
- HALT: halted=1; instr_valid=0; pc and IR hold their values; the block stays in HALT until rst.
- Throughput: 4 cycles per instruction with no stall; each stall cycle adds 1.
- Wrap-around: pc=2^PC_WIDTH-1 with code 3 gives pc=0. Branch arithmetic is modular in both directions.
- pc_sel and jr_target are ignored outside EXEC.
- stall is ignored outside EXEC.
- illegal_sel is cleared only by rst.
- IR fields are stable from DECODE through the end of EXEC. This includes stall cycles, so repeated control-unit re-registration is consistent.

Test Plan:
1. rst high 2 cycles, then low; im[0]=0x0C000000 (opcode 3), pc_sel=3 in EXEC → im_addr=0, opcode=3 and instr_valid=1 on cycles 3-4, pc=1 at cycle 5, FETCH of address 1.
2. Branch at pc=0x0010, imm=0xFFFC, pc_sel=1 → pc=0x000D. Branch at pc=0xFFFF, imm=0x0002, pc_sel=1 → pc=0x0002.
3. pc_sel=0 with imm=0x1234 → pc=0x1234. pc_sel=2 with jr_target=0x00A0 → pc=0x00A0.
4. stall=1 for 3 cycles in EXEC with pc_sel=3 → pc held and opcode stable; the instruction completes in 7 cycles and pc increments once.
5. pc_sel=4 in EXEC → halted=1 next cycle; pc held; no further im_addr change for 10 cycles. Then rst → halted=0, pc=RESET_PC.
6. pc_sel=6 in EXEC at pc=5 → pc=6 and illegal_sel=1, staying set across later instructions. Asserting rst during LATCH → next cycle state FETCH, pc=0, instr_valid=0, illegal_sel=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundle between the fetch sequencer, instruction memory and control unit
//   master (sequencer): drives im_addr, opcode/rs1/rs2/imm, instr_valid, pc, halted, illegal_sel
//                       receives im_rdata, pc_sel, jr_target, stall
//   slave  (environment): the mirror image
interface fetch_sequencer_if #(parameter int PC_WIDTH = 16);
  logic [PC_WIDTH-1:0] im_addr;
  logic [31:0] im_rdata;
  logic [5:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [15:0] imm;
  logic instr_valid;
  logic [2:0] pc_sel;
  logic [PC_WIDTH-1:0] jr_target;
  logic stall;
  logic [PC_WIDTH-1:0] pc;
  logic halted;
  logic illegal_sel;
  modport master (
    output im_addr, opcode, rs1, rs2, imm, instr_valid, pc, halted, illegal_sel,
    input im_rdata, pc_sel, jr_target, stall
  );
  modport slave (
    input im_addr, opcode, rs1, rs2, imm, instr_valid, pc, halted, illegal_sel,
    output im_rdata, pc_sel, jr_target, stall
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC holder and 4-state instruction fetch front end feeding the control unit
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of fetch_sequencer_if (memory address/data, IR fields, pc_sel/jr_target/stall, status)
module fetch_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_HALT} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, imm_pc;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic illegal_q, illegal_d;
  assign pc_inc = pc_q + PC_WIDTH'(1);
  // PC_WIDTH <= 16, so truncating imm equals sign-extending then wrapping mod 2^PC_WIDTH
  assign imm_pc = ir_q[PC_WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d = bus.im_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: if (!bus.stall) begin
        state_d = bus.pc_sel == 3'd4 ? S_HALT : S_FETCH;
        pc_d = bus.pc_sel == 3'd0 ? imm_pc :
               bus.pc_sel == 3'd1 ? pc_inc + imm_pc :
               bus.pc_sel == 3'd2 ? bus.jr_target :
               bus.pc_sel == 3'd4 ? pc_q : pc_inc;
        illegal_d = illegal_q | (bus.pc_sel >= 3'd5);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.im_addr = pc_q;
  assign bus.pc = pc_q;
  assign bus.opcode = ir_q[31:26];
  assign bus.rs1 = ir_q[25:21];
  assign bus.rs2 = ir_q[20:16];
  assign bus.imm = ir_q[15:0];
  assign bus.instr_valid = state_q == S_DECODE || state_q == S_EXEC;
  assign bus.halted = state_q == S_HALT;
  assign bus.illegal_sel = illegal_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer with a synchronous instruction memory model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:65535];
  logic [15:0] mpc;
  typedef struct packed {
    logic [31:0] ins;
    logic [15:0] npc;
  } exp_t;
  exp_t q[$];
  exp_t cur = '0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_WIDTH(16)) bus();
  fetch_sequencer #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) bus.im_rdata <= mem[bus.im_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on instr_valid rising, check fields every valid cycle, check PC when valid drops
  always @(negedge clk) begin
    if (bus.instr_valid && !prev_v) begin
      if (q.size() == 0) chk("sb_unexpected", 1, 0);
      else cur = q.pop_front();
    end
    if (bus.instr_valid) chk("ir_fields", {bus.opcode, bus.rs1, bus.rs2, bus.imm}, cur.ins);
    if (!bus.instr_valid && prev_v) chk("next_pc", {16'h0, bus.pc}, {16'h0, cur.npc});
    prev_v = bus.instr_valid;
  end

  // Called #1 after a posedge with the DUT in FETCH; garbage pc_sel=4 and stall=1 outside EXEC must be ignored
  task automatic run_instr(input logic [31:0] ins, input logic [2:0] sel, input logic [15:0] jr,
                           input int stalls, input logic [15:0] exp_pc);
    mem[mpc] = ins;
    q.push_back('{ins: ins, npc: exp_pc});
    bus.stall = 1'b1;
    bus.pc_sel = 3'd4;
    bus.jr_target = 16'($urandom);
    @(negedge clk);
    chk("fetch_addr", {16'h0, bus.im_addr}, {16'h0, mpc});
    chk("fetch_valid", {31'h0, bus.instr_valid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latch_valid", {31'h0, bus.instr_valid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("decode_valid", {31'h0, bus.instr_valid}, 1);
    @(posedge clk); #1;
    bus.pc_sel = sel;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      chk("stall_pc", {16'h0, bus.pc}, {16'h0, mpc});
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    bus.jr_target = jr;
    @(negedge clk);
    chk("exec_valid", {31'h0, bus.instr_valid}, 1);
    @(posedge clk); #1;
    bus.pc_sel = 3'd4;
    bus.stall = 1'b1;
    if (sel == 3'd4) chk("halted", {31'h0, bus.halted}, 1);
    else chk("refetch_addr", {16'h0, bus.im_addr}, {16'h0, exp_pc});
    mpc = exp_pc;
  endtask

  task automatic check_reset_state();
    chk("rst_pc", {16'h0, bus.pc}, 0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 0);
    chk("rst_halted", {31'h0, bus.halted}, 0);
    chk("rst_illegal", {31'h0, bus.illegal_sel}, 0);
    chk("rst_ir", {bus.opcode, bus.rs1, bus.rs2, bus.imm}, 0);
    mpc = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    bus.pc_sel = 3'd0;
    bus.jr_target = 16'h0;
    bus.stall = 1'b0;
    mpc = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    run_instr(32'h0C000000, 3'd3, 16'h0000, 0, 16'h0001);
    run_instr(32'h04A30010, 3'd0, 16'h0000, 0, 16'h0010);
    run_instr(32'h10E4FFFC, 3'd1, 16'h0000, 0, 16'h000D);
    run_instr(32'h0800FFFF, 3'd0, 16'h0000, 0, 16'hFFFF);
    run_instr(32'h14210002, 3'd1, 16'h0000, 0, 16'h0002);
    run_instr(32'h08001234, 3'd0, 16'h0000, 0, 16'h1234);
    run_instr(32'h1BE00000, 3'd2, 16'h00A0, 0, 16'h00A0);
    run_instr(32'h0C5A5A5A, 3'd3, 16'h0000, 3, 16'h00A1);
    run_instr(32'h08000005, 3'd0, 16'h0000, 0, 16'h0005);
    chk("illegal_before", {31'h0, bus.illegal_sel}, 0);
    run_instr(32'h2C000000, 3'd6, 16'h0000, 0, 16'h0006);
    chk("illegal_set", {31'h0, bus.illegal_sel}, 1);
    run_instr(32'h0C000001, 3'd3, 16'h0000, 0, 16'h0007);
    run_instr(32'h0800FFFF, 3'd0, 16'h0000, 0, 16'hFFFF);
    run_instr(32'h0C0000FF, 3'd3, 16'h0000, 0, 16'h0000);
    chk("illegal_sticky", {31'h0, bus.illegal_sel}, 1);
    // reset asserted during LATCH discards the in-flight instruction
    mem[mpc] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    run_instr(32'h0C000000, 3'd3, 16'h0000, 0, 16'h0001);
    run_instr(32'h10000000, 3'd4, 16'h0000, 0, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_hold", {14'h0, bus.halted, bus.instr_valid, bus.im_addr}, {14'h0, 1'b1, 1'b0, 16'h0001});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    run_instr(32'h0C000000, 3'd3, 16'h0000, 0, 16'h0001);
    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
